// File: rtl/y86_fetch_queue_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side signals.
//
// master : the fetch queue. Drives imem_req/imem_addr and the decoded
//          instruction (out_valid, icode, ifun, rA, rB, valC, valP, pc,
//          pred_pc, instr_valid, mem_error). Receives imem_rdata/imem_error,
//          redirect/redirect_pc and out_ready.
// slave  : the environment (instruction memory plus the later pipeline
//          stages), with every direction reversed.
interface y86_fetch_queue_if #(
  parameter int FETCH_BYTES = 8
);
  logic                     imem_req;
  logic [63:0]              imem_addr;
  logic [8*FETCH_BYTES-1:0] imem_rdata;
  logic                     imem_error;

  logic                     redirect;
  logic [63:0]              redirect_pc;

  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               icode;
  logic [3:0]               ifun;
  logic [3:0]               rA;
  logic [3:0]               rB;
  logic [63:0]              valC;
  logic [63:0]              valP;
  logic [63:0]              pc;
  logic [63:0]              pred_pc;
  logic                     instr_valid;
  logic                     mem_error;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_error,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output icode, ifun, rA, rB, valC, valP, pc, pred_pc, instr_valid, mem_error
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_error,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  icode, ifun, rA, rB, valC, valP, pc, pred_pc, instr_valid, mem_error
  );
endinterface

// File: rtl/y86_fetch_queue.sv
// Prefetching fetch stage for the pipelined Y86-64 core.
//
// Reads FETCH_BYTES instruction bytes per request into a circular byte
// queue of BUF_BYTES entries (each byte tagged with the memory error flag
// that came back with it) and decodes one variable-length instruction per
// cycle from the queue head. jXX/call are predicted taken (fetch restarts at
// valC), ret parks the stage until a redirect, and halt / illegal /
// faulting instructions stop it.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high
//   bus   - y86_fetch_queue_if.master: imem request/return, redirect in,
//           decoded instruction out over out_valid/out_ready.
module y86_fetch_queue #(
  parameter int          FETCH_BYTES = 8,
  parameter int          BUF_BYTES   = 32,
  parameter logic [63:0] RESET_PC    = 64'd0
) (
  input  logic              clk,
  input  logic              reset,
  y86_fetch_queue_if.master bus
);
  localparam int CNT_W      = $clog2(BUF_BYTES + 1);
  localparam int PTR_W      = $clog2(BUF_BYTES);
  localparam int HEAD_BYTES = 10;  // longest Y86 instruction

  typedef enum logic [1:0] {S_RUN, S_WAIT_RET, S_HALTED} state_t;

  state_t            state_reg, state_next;
  logic [PTR_W-1:0]  head_ptr_reg, head_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [63:0]       fetch_pc_reg, fetch_pc_next;
  logic [63:0]       head_pc_reg, head_pc_next;
  logic              inflight_reg;
  logic              squash_reg;

  logic [7:0]        q_data [BUF_BYTES];
  logic              q_err  [BUF_BYTES];

  // ---------------------------------------------------------------- head view
  logic [7:0]            hb [HEAD_BYTES];
  logic [HEAD_BYTES-1:0] he;

  for (genvar gi = 0; gi < HEAD_BYTES; gi++) begin : g_head
    logic [PTR_W:0]   raw;
    logic [PTR_W-1:0] idx;
    assign raw   = {1'b0, head_ptr_reg} + (PTR_W+1)'(gi);
    assign idx   = (raw >= (PTR_W+1)'(BUF_BYTES)) ? PTR_W'(raw - (PTR_W+1)'(BUF_BYTES))
                                                  : PTR_W'(raw);
    assign hb[gi] = q_data[idx];
    assign he[gi] = q_err[idx];
  end

  // ------------------------------------------------------------------ decode
  logic [3:0]  h_icode, h_ifun;
  logic [3:0]  len;
  logic        has_regs, has_valc_at2, is_jc, is_ret;
  logic        d_instr_valid, d_mem_error;
  logic [63:0] d_valc, d_valp, d_pred_pc;

  assign h_icode = hb[0][7:4];
  assign h_ifun  = hb[0][3:0];

  // A faulting head byte is not trusted: it is a 1-byte instruction with no
  // operands, so the fault surfaces without waiting for more bytes.
  always_comb begin
    len          = 4'd1;
    has_regs     = 1'b0;
    has_valc_at2 = 1'b0;
    is_jc        = 1'b0;
    is_ret       = 1'b0;
    if (!he[0]) begin
      case (h_icode)
        4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  has_regs = 1'b1; end
        4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_regs = 1'b1; has_valc_at2 = 1'b1; end
        4'h7, 4'h8:             begin len = 4'd9;  is_jc = 1'b1; end
        4'h9:                   is_ret = 1'b1;
        default:                len = 4'd1;
      endcase
    end
  end

  always_comb begin
    d_valc = '0;
    if (has_valc_at2) begin
      for (int i = 0; i < 8; i++) d_valc[8*i +: 8] = hb[i+2];
    end else if (is_jc) begin
      for (int i = 0; i < 8; i++) d_valc[8*i +: 8] = hb[i+1];
    end
  end

  always_comb begin
    d_mem_error = 1'b0;
    for (int i = 0; i < HEAD_BYTES; i++) begin
      if (4'(i) < len) d_mem_error = d_mem_error | he[i];
    end
  end

  always_comb begin
    case (h_icode)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: d_instr_valid = (h_ifun == 4'h0);
      4'h2, 4'h7: d_instr_valid = (h_ifun <= 4'h6);
      4'h6:       d_instr_valid = (h_ifun <= 4'h3);
      default:    d_instr_valid = 1'b0;
    endcase
  end

  assign d_valp    = head_pc_reg + 64'(len);
  assign d_pred_pc = is_jc ? d_valc : d_valp;

  // --------------------------------------------------------------- handshake
  logic out_valid_int, fire, halt_cond, leave_run, flush, issue, append;
  logic [CNT_W+1:0] need;

  assign out_valid_int = !reset && (state_reg != S_HALTED) && (count_reg >= CNT_W'(len));
  assign fire          = out_valid_int && bus.out_ready && !bus.redirect;
  assign halt_cond     = (h_icode == 4'h0) || !d_instr_valid || d_mem_error;
  // Anything that ends the straight-line byte stream discards what is
  // queued behind it (for ret the following bytes are off the path too).
  assign leave_run     = fire && (halt_cond || is_jc || is_ret);
  assign flush         = bus.redirect || leave_run;

  // Room must exist for the read already in flight plus the new one.
  assign need  = (CNT_W+2)'(count_reg)
               + (inflight_reg ? (CNT_W+2)'(FETCH_BYTES) : '0)
               + (CNT_W+2)'(FETCH_BYTES);
  assign issue = !reset && (state_reg == S_RUN) && !bus.redirect
              && (need <= (CNT_W+2)'(BUF_BYTES));
  assign append = inflight_reg && !squash_reg && !flush;

  // -------------------------------------------------------- queue addressing
  logic [PTR_W:0]   tail_raw, pop_raw;
  logic [PTR_W-1:0] tail_ptr, pop_ptr;
  logic [PTR_W-1:0] wr_idx [FETCH_BYTES];

  assign tail_raw = {1'b0, head_ptr_reg} + (PTR_W+1)'(count_reg);
  assign tail_ptr = (tail_raw >= (PTR_W+1)'(BUF_BYTES)) ? PTR_W'(tail_raw - (PTR_W+1)'(BUF_BYTES))
                                                        : PTR_W'(tail_raw);
  assign pop_raw  = {1'b0, head_ptr_reg} + (PTR_W+1)'(len);
  assign pop_ptr  = (pop_raw >= (PTR_W+1)'(BUF_BYTES)) ? PTR_W'(pop_raw - (PTR_W+1)'(BUF_BYTES))
                                                       : PTR_W'(pop_raw);

  for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_wr
    logic [PTR_W:0] raw;
    assign raw        = {1'b0, tail_ptr} + (PTR_W+1)'(gi);
    assign wr_idx[gi] = (raw >= (PTR_W+1)'(BUF_BYTES)) ? PTR_W'(raw - (PTR_W+1)'(BUF_BYTES))
                                                       : PTR_W'(raw);
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_next    = state_reg;
    head_ptr_next = head_ptr_reg;
    count_next    = count_reg;
    fetch_pc_next = fetch_pc_reg;
    head_pc_next  = head_pc_reg;

    if (issue)  fetch_pc_next = fetch_pc_reg + 64'(FETCH_BYTES);
    if (append) count_next    = count_reg + CNT_W'(FETCH_BYTES);
    if (fire) begin
      head_pc_next  = d_pred_pc;
      head_ptr_next = pop_ptr;
      count_next    = count_next - CNT_W'(len);
    end
    if (leave_run) begin
      count_next    = '0;
      head_ptr_next = '0;
      if (halt_cond)   state_next    = S_HALTED;
      else if (is_ret) state_next    = S_WAIT_RET;
      else             fetch_pc_next = d_valc;
    end
    if (bus.redirect) begin
      count_next    = '0;
      head_ptr_next = '0;
      fetch_pc_next = bus.redirect_pc;
      head_pc_next  = bus.redirect_pc;
      state_next    = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr_reg <= '0;
      count_reg    <= '0;
      fetch_pc_reg <= RESET_PC;
      head_pc_reg  <= RESET_PC;
      inflight_reg <= 1'b0;
      squash_reg   <= 1'b0;
    end else begin
      head_ptr_reg <= head_ptr_next;
      count_reg    <= count_next;
      fetch_pc_reg <= fetch_pc_next;
      head_pc_reg  <= head_pc_next;
      inflight_reg <= issue;
      // A read issued in the same cycle the stream is abandoned belongs to
      // the old path; its return is dropped.
      squash_reg   <= issue && leave_run;
    end
  end

  // Queue storage needs no reset: count_reg decides which bytes are live.
  always_ff @(posedge clk) begin
    if (append) begin
      for (int j = 0; j < FETCH_BYTES; j++) begin
        q_data[wr_idx[j]] <= bus.imem_rdata[8*j +: 8];
        q_err[wr_idx[j]]  <= bus.imem_error;
      end
    end
  end

  // ----------------------------------------------------------------- outputs
  assign bus.imem_req    = issue;
  assign bus.imem_addr   = fetch_pc_reg;
  assign bus.out_valid   = out_valid_int;
  assign bus.icode       = out_valid_int ? h_icode : 4'h0;
  assign bus.ifun        = out_valid_int ? h_ifun  : 4'h0;
  assign bus.rA          = (out_valid_int && has_regs) ? hb[1][7:4] : 4'hF;
  assign bus.rB          = (out_valid_int && has_regs) ? hb[1][3:0] : 4'hF;
  assign bus.valC        = out_valid_int ? d_valc      : 64'd0;
  assign bus.valP        = out_valid_int ? d_valp      : 64'd0;
  assign bus.pc          = out_valid_int ? head_pc_reg : 64'd0;
  assign bus.pred_pc     = out_valid_int ? d_pred_pc   : 64'd0;
  assign bus.instr_valid = out_valid_int && d_instr_valid;
  assign bus.mem_error   = out_valid_int && d_mem_error;
endmodule

// File: tb/tb_y86_fetch_queue.sv
module tb_y86_fetch_queue;
  localparam int FB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  y86_fetch_queue_if #(.FETCH_BYTES(FB)) bus ();

  y86_fetch_queue #(.FETCH_BYTES(FB), .BUF_BYTES(32), .RESET_PC(64'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: data for a request appears the cycle after it.
  logic [7:0] mem [256];
  logic [7:0] cap_addr;
  logic       cap_req;
  logic       err_en;
  logic [7:0] err_addr;

  always @(posedge clk) begin
    cap_addr <= bus.imem_addr[7:0];
    cap_req  <= bus.imem_req;
  end

  for (genvar gi = 0; gi < FB; gi++) begin : g_mem
    assign bus.imem_rdata[8*gi +: 8] = mem[8'(cap_addr + 8'(gi))];
  end
  assign bus.imem_error = cap_req && err_en && (cap_addr == err_addr);

  typedef struct packed {
    logic [79:0] ibytes;  // instruction bytes, little-endian (stimulus)
    logic [3:0]  ilen;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc, pred_pc;
    logic        iv, me;
  } vec_t;

  vec_t tbl [12];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic [79:0] b, input logic [3:0] l,
                              input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] c, input logic [63:0] p,
                              input logic [63:0] at, input logic [63:0] pr,
                              input logic iv, input logic me);
    vec_t v;
    v = '{b, l, ic, fn, ra, rb, c, p, at, pr, iv, me};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic fill_mem(input logic [7:0] val);
    for (int a = 0; a < 256; a++) mem[a] = val;
  endtask

  task automatic place(input int i);
    for (int k = 0; k < int'(tbl[i].ilen); k++)
      mem[8'(tbl[i].pc + 64'(k))] = tbl[i].ibytes[8*k +: 8];
  endtask

  task automatic compare_vec(input int i);
    chk($sformatf("v%0d.out_valid", i), 64'(bus.out_valid), 64'd1);
    chk($sformatf("v%0d.icode", i), 64'(bus.icode), 64'(tbl[i].icode));
    chk($sformatf("v%0d.ifun", i), 64'(bus.ifun), 64'(tbl[i].ifun));
    chk($sformatf("v%0d.rA", i), 64'(bus.rA), 64'(tbl[i].rA));
    chk($sformatf("v%0d.rB", i), 64'(bus.rB), 64'(tbl[i].rB));
    chk($sformatf("v%0d.valC", i), bus.valC, tbl[i].valC);
    chk($sformatf("v%0d.valP", i), bus.valP, tbl[i].valP);
    chk($sformatf("v%0d.pc", i), bus.pc, tbl[i].pc);
    chk($sformatf("v%0d.pred_pc", i), bus.pred_pc, tbl[i].pred_pc);
    chk($sformatf("v%0d.instr_valid", i), 64'(bus.instr_valid), 64'(tbl[i].iv));
    chk($sformatf("v%0d.mem_error", i), 64'(bus.mem_error), 64'(tbl[i].me));
    $display("txn v%0d pc=0x%0h icode=%0h ifun=%0h rA=%0h rB=%0h valC=0x%0h valP=0x%0h pred=0x%0h iv=%0b me=%0b",
             i, bus.pc, bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC, bus.valP,
             bus.pred_pc, bus.instr_valid, bus.mem_error);
  endtask

  // Waits (bounded) for out_valid, then checks the head against vector i.
  // The handshake completes on the following posedge when out_ready is high.
  task automatic expect_vec(input int i);
    int n = 0;
    @(negedge clk); #1;
    while (bus.out_valid !== 1'b1 && n < 64) begin
      @(negedge clk); #1;
      n++;
    end
    compare_vec(i);
  endtask

  task automatic idle_check(input string nm, input int cycles);
    int reqs = 0;
    int vals = 0;
    repeat (cycles) begin
      @(negedge clk); #1;
      reqs += int'(bus.imem_req);
      vals += int'(bus.out_valid);
    end
    chk({nm, ".imem_req_cycles"}, 64'(reqs), 64'd0);
    chk({nm, ".out_valid_cycles"}, 64'(vals), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.redirect = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tbl[0]  = mk({64'd10, 8'hF2, 8'h30}, 10, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 64'd0, 64'd10, 1, 0);
    tbl[1]  = mk({8'h20, 8'h60}, 2, 4'h6, 4'h0, 4'h2, 4'h0, 64'd0, 64'd12, 64'd10, 64'd12, 1, 0);
    tbl[2]  = mk(80'h00, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd13, 64'd12, 64'd13, 1, 0);
    tbl[3]  = mk({64'h0123456789ABCDEF, 8'hF3, 8'h30}, 10, 4'h3, 4'h0, 4'hF, 4'h3,
                 64'h0123456789ABCDEF, 64'd16, 64'd6, 64'd16, 1, 0);
    tbl[4]  = mk({64'h40, 8'h70}, 9, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'd9, 64'd0, 64'h40, 1, 0);
    tbl[5]  = mk(80'h10, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 64'h40, 64'h41, 1, 0);
    tbl[6]  = mk(80'h00, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h42, 64'h41, 64'h42, 1, 0);
    tbl[7]  = mk(80'h90, 1, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd0, 64'd1, 1, 0);
    tbl[8]  = mk(80'h10, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h81, 64'h80, 64'h81, 1, 0);
    tbl[9]  = mk(80'h00, 1, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h82, 64'h81, 64'h82, 1, 0);
    tbl[10] = mk(80'h10, 1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd9, 64'd8, 64'd9, 1, 1);
    // cmov with ifun 7 is outside the cmovXX range
    tbl[11] = mk({8'h01, 8'h27}, 2, 4'h2, 4'h7, 4'h0, 4'h1, 64'd0, 64'd2, 64'd0, 64'd2, 0, 0);

    reset = 1'b1;
    err_en = 1'b0;
    err_addr = 8'd0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 64'd0;
    bus.out_ready = 1'b1;

    // ---- straight-line program: irmovq, addq, halt
    fill_mem(8'h00);
    place(0); place(1); place(2);
    repeat (3) @(negedge clk);
    #1;
    chk("reset.imem_req", 64'(bus.imem_req), 64'd0);
    chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset.icode", 64'(bus.icode), 64'd0);
    chk("reset.rA", 64'(bus.rA), 64'hF);
    chk("reset.rB", 64'(bus.rB), 64'hF);
    chk("reset.valC", bus.valC, 64'd0);
    chk("reset.valP", bus.valP, 64'd0);
    chk("reset.pred_pc", bus.pred_pc, 64'd0);
    chk("reset.instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("reset.imem_addr", bus.imem_addr, 64'd0);
    reset = 1'b0;
    #1;
    chk("start.imem_req", 64'(bus.imem_req), 64'd1);
    for (int i = 0; i < 3; i++) expect_vec(i);
    idle_check("halted", 6);

    // ---- redirect out of HALTED onto an irmovq that spans two reads
    fill_mem(8'h00);
    place(3);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'd6;
    #1;
    chk("redir.imem_req_blocked", 64'(bus.imem_req), 64'd0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("span.first_req", 64'(bus.imem_req), 64'd1);
    chk("span.first_addr", bus.imem_addr, 64'd6);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk($sformatf("span.early_valid%0d", k), 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk); #1;
    compare_vec(3);

    // ---- taken jmp with garbage behind it
    fill_mem(8'hFF);
    place(4); place(5); place(6);
    do_reset();
    expect_vec(4);
    n = 0;
    @(negedge clk); #1;
    while (bus.imem_req !== 1'b1 && n < 16) begin
      @(negedge clk); #1;
      n++;
    end
    chk("jmp.next_req", 64'(bus.imem_req), 64'd1);
    chk("jmp.next_addr", bus.imem_addr, 64'h40);
    expect_vec(5);
    expect_vec(6);

    // ---- ret parks the stage until a redirect
    fill_mem(8'hFF);
    place(7); place(8); place(9);
    do_reset();
    expect_vec(7);
    idle_check("wait_ret", 5);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 64'h80;
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("ret.redir_req", 64'(bus.imem_req), 64'd1);
    chk("ret.redir_addr", bus.imem_addr, 64'h80);
    expect_vec(8);
    expect_vec(9);

    // ---- backpressure: queue fills to capacity, then drains in order
    fill_mem(8'h00);
    for (int a = 0; a < 64; a++) mem[a] = 8'h10;
    bus.out_ready = 1'b0;
    do_reset();
    n = int'(bus.imem_req);
    repeat (20) begin
      @(negedge clk); #1;
      n += int'(bus.imem_req);
    end
    chk("bp.total_reqs", 64'(n), 64'd4);
    chk("bp.req_stopped", 64'(bus.imem_req), 64'd0);
    chk("bp.held_pc", bus.pc, 64'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      chk($sformatf("bp.valid%0d", k), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp.pc%0d", k), bus.pc, 64'(k));
      chk($sformatf("bp.icode%0d", k), 64'(bus.icode), 64'h1);
      $display("txn nop pc=0x%0h valid=%0b", bus.pc, bus.out_valid);
    end

    // ---- memory error on the second read
    fill_mem(8'h10);
    err_en = 1'b1;
    err_addr = 8'd8;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      n = 0;
      @(negedge clk); #1;
      while (bus.out_valid !== 1'b1 && n < 32) begin
        @(negedge clk); #1;
        n++;
      end
      chk($sformatf("err.pc%0d", k), bus.pc, 64'(k));
      chk($sformatf("err.me%0d", k), 64'(bus.mem_error), 64'd0);
    end
    expect_vec(10);
    idle_check("err_halt", 4);
    err_en = 1'b0;

    // ---- illegal instruction halts
    fill_mem(8'h10);
    place(11);
    do_reset();
    expect_vec(11);
    idle_check("illegal_halt", 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
